keccak_padder_param: RTL
========================

// Module: keccak_padder_param
// PURPOSE
//  Parametrised Keccak/SHA-3 input padder. Packs user words into a RATE_BITS-wide block and applies multi-rate
//  padding with a selectable domain byte: SHA3 0x06 or SHAKE 0x1F. Emits one or more blocks per message to the
//  f_permutation core and returns to accepting a new message without reset. Sits between the user stream and f_permutation.
// PARAMETERS
//  RATE_BITS  1088  block width in bits; 1088 = SHA3-256/SHAKE256, 1344 = SHAKE128; must be a multiple of IN_W
//  IN_W       32    input word width in bits; a multiple of 8, at least 16
//  WORDS      RATE_BITS/IN_W (localparam)  words per block; CW = $clog2(WORDS+1) counter width
// PORTS
//  clk        in   1          single clock
//  reset_n    in   1          synchronous, active-low reset
//  in         in   IN_W       message word; first byte in in[IN_W-1 -: 8]
//  in_valid   in   1          in, is_last, byte_num and mode are valid
//  is_last    in   1          final word of message; only meaningful when in_valid=1
//  byte_num   in   clog2(IN_W/8)  valid bytes in the last word (0..IN_W/8-1); ignored when is_last=0 (full word)
//  mode       in   1          0 = SHA3 (0x06), 1 = SHAKE (0x1F); sampled on the first accepted word of a message
//  in_ack     out  1          word consumed this cycle; the user advances only when in_ack=1
//  out        out  RATE_BITS  block; the first word is in the MSBs and the newest word is shifted into the LSBs
//  out_valid  out  1          block full and stable
//  f_ack      in   1          permutation took the block; clears the buffer
//  msg_done   out  1          1-cycle pulse when the final padded block of a message is acked
// BEHAVIOUR
//  Reset (reset_n=0 at posedge; overrides everything, including mid-block): out=0, out_valid=0, in_ack=0,
//   msg_done=0, cnt=0, state=ABSORB, mode_q=0.
//  in_ack = in_valid & (state==ABSORB) & ~full. Combinational; no registered latency.
//  update = in_ack | (state==PAD & ~full). On update: out <= {out[RATE_BITS-IN_W-1:0], w}; cnt <= cnt+1.
//  full = (cnt==WORDS); out_valid = full. A block is valid the cycle after its WORDS-th word is shifted in.
//  While full: no update and in_ack=0. On f_ack & full: cnt <= 0 and out is held. f_ack while not full is ignored.
//  States:
//   ABSORB: w = in when is_last=0. On an accepted is_last: w = pad_word(in, byte_num, dom) and state -> PAD.
//   PAD: w = 0, emitted until the block fills. The domain byte was already placed on the last word.
//   FINAL (entered on PAD & full, or on the is_last word filling the block): waits for f_ack,
//    then pulses msg_done, cnt=0 and state -> ABSORB.
//  pad_word: bytes [0..byte_num-1] come from in, byte[byte_num] = dom, and higher bytes are 0.
//  End bit: bit 7 of the LSB byte is OR'd with 1 (0x80) whenever the word being shifted is word index WORDS-1
//   of a padded block (state PAD, or an is_last word landing at cnt==WORDS-1).
//   Domain and end bit in the same byte merge to 0x86 (SHA3) or 0x9F (SHAKE).
//  Exact multiple of the rate: the message is sent as full words, then a final is_last word with byte_num=0.
//   That word falls into a fresh block and yields {dom,0..}..0x80 as the extra block.
//  is_last is registered only on an accepted word. is_last with in_valid=0 or in_ack=0 has no effect.
//  mode_q latches mode on the first accepted word (cnt==0 in ABSORB after reset or msg_done) and is held to msg end.
//  in_valid during FINAL or PAD: in_ack=0 and the word stays on the bus until the next message starts.
// STRUCTURE
//  keccak_pkg: DOM_SHA3=8'h06, DOM_SHAKE=8'h1F, PAD_END=8'h80, RATE_SHA3_256=1088, RATE_SHAKE128=1344, state enum.
//  One sub-module, keccak_pad_word (combinational, param IN_W): in, byte_num, dom -> padded word. The top holds the FSM,
//   the counter and the shift register.
// TESTING (IN_W=32, RATE_BITS=1088, WORDS=34 unless noted)
//  1 Empty SHA3 msg: is_last, byte_num=0, mode=0 -> one block: word0=0x06000000, words1..32=0, word33=0x00000080;
//    out_valid 34 cycles after accept; f_ack -> msg_done pulse.
//  2 SHAKE, 3 bytes: in=0xAABBCC00, byte_num=3, mode=1 -> word0=0xAABBCC1F ... word33=0x00000080.
//  3 SHA3, 33 full words then is_last with in=0xAABBCC00, byte_num=3 -> word33=0xAABBCC86, one block only.
//  4 SHA3, 34 full words then is_last with byte_num=0 -> block1 raw, in_ack=0 until f_ack;
//    block2 word0=0x06000000, word33=0x00000080, one msg_done.
//  5 Back-to-back: msg A SHA3 -> msg_done -> msg B SHAKE, no reset in between -> B's domain byte is 0x1F;
//    rerun case 2 with RATE_BITS=1344 and IN_W=64 -> last word=0x...80 at index 20.
//  6 reset_n=0 at cnt=17 -> next cycle out=0, out_valid=0, in_ack=0; then case 1 passes unchanged.

Source files
------------

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants for the Keccak/SHA-3 input padder
package keccak_pkg;
  localparam logic [7:0] DOM_SHA3 = 8'h06;
  localparam logic [7:0] DOM_SHAKE = 8'h1F;
  localparam logic [7:0] PAD_END = 8'h80;
  localparam int RATE_SHA3_256 = 1088;
  localparam int RATE_SHAKE128 = 1344;
  localparam logic [1:0] ABSORB = 2'd0;
  localparam logic [1:0] PAD = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
endpackage

// File: rtl/keccak_pad_word.sv
// keccak_pad_word: keeps the leading byte_num bytes, places the domain byte after them, zeroes the rest
module keccak_pad_word #(
  parameter int IN_W = 32
) (
  input  logic [IN_W-1:0]             in,
  input  logic [$clog2(IN_W/8)-1:0]   byte_num,
  input  logic [7:0]                  dom,
  output logic [IN_W-1:0]             padded
);
  localparam int BW = $clog2(IN_W/8);
  for (genvar b = 0; b < IN_W/8; b++) begin : g_byte
    localparam logic [BW-1:0] IDX = BW'(b);
    assign padded[IN_W-1-8*b -: 8] = IDX < byte_num ? in[IN_W-1-8*b -: 8] :
                                     IDX == byte_num ? dom : 8'h00;
  end
endmodule

// File: rtl/keccak_padder_param.sv
// keccak_padder_param: packs user words into rate-wide blocks and applies Keccak multi-rate padding
module keccak_padder_param
  import keccak_pkg::*;
#(
  parameter int RATE_BITS = RATE_SHA3_256,
  parameter int IN_W = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [IN_W-1:0]             in,
  input  logic                        in_valid,
  input  logic                        is_last,
  input  logic [$clog2(IN_W/8)-1:0]   byte_num,
  input  logic                        mode,
  output logic                        in_ack,
  output logic [RATE_BITS-1:0]        out,
  output logic                        out_valid,
  input  logic                        f_ack,
  output logic                        msg_done
);
  localparam int WORDS = RATE_BITS/IN_W;
  localparam int CW = $clog2(WORDS+1);
  localparam logic [CW-1:0] LAST = CW'(WORDS-1);
  localparam logic [CW-1:0] FULL_CNT = CW'(WORDS);
  logic [CW-1:0] cnt;
  logic [1:0] state, state_n;
  logic mode_q, fresh, full, update, last_acc, end_bit, fin;
  logic [IN_W-1:0] pw, w;
  // the first word of a message must use the live mode since mode_q is only latched on that edge
  keccak_pad_word #(.IN_W(IN_W)) u_pad (
    .in(in),
    .byte_num(byte_num),
    .dom((fresh ? mode : mode_q) ? DOM_SHAKE : DOM_SHA3),
    .padded(pw)
  );
  always_comb begin
    full = cnt == FULL_CNT;
    in_ack = reset_n & in_valid & (state == ABSORB) & ~full;
    update = in_ack | ((state == PAD) & ~full);
    last_acc = in_ack & is_last;
    fin = (state == FINAL) & f_ack & full;
    end_bit = ((state == PAD) | last_acc) & (cnt == LAST);
    w = ((state == PAD) ? '0 : last_acc ? pw : in) | {{(IN_W-8){1'b0}}, end_bit ? PAD_END : 8'h00};
    state_n = last_acc ? ((cnt == LAST) ? FINAL : PAD) :
              ((state == PAD) & update & (cnt == LAST)) ? FINAL :
              fin ? ABSORB : state;
    out_valid = full;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out <= '0;
      cnt <= '0;
      state <= ABSORB;
      mode_q <= 1'b0;
      fresh <= 1'b1;
      msg_done <= 1'b0;
    end else begin
      msg_done <= fin;
      state <= state_n;
      if (update) begin
        out <= {out[RATE_BITS-IN_W-1:0], w};
        cnt <= cnt + 1'b1;
      end else if (f_ack & full) cnt <= '0;
      if (in_ack & fresh) mode_q <= mode;
      if (in_ack) fresh <= 1'b0;
      else if (fin) fresh <= 1'b1;
    end
  end
endmodule
